pipe_scoreboard: RTL and testbench
==================================

// Module: pipe_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding scoreboard for the in-order pipeline.
//  Replaces the fixed load-use check and 2-way forwarding with a DEPTH-entry shift register of in-flight writes.
//  Sits beside ID: takes the decoded ID instruction and returns a stall request and a per-operand forward-source index.
//  Supports configurable load latency, an arbitrary number of post-ID stages, branch flush and a global hold.
// PARAMETERS
//  REG_BITS    5  register index width
//  DEPTH       3  tracked stages after ID; entry 0 = EX, 1 = MEM, 2 = WB
//  ALU_AVAIL   1  stages after EX at which an ALU result becomes forwardable
//  LOAD_AVAIL  2  stages after EX at which load data becomes forwardable
//  FLUSH_DEPTH 1  youngest entries squashed on flush (0..DEPTH)
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              synchronous, active-high
//  id_valid    in   1              ID holds a real instruction
//  id_rs       in   REG_BITS       source reg 1
//  id_rt       in   REG_BITS       source reg 2
//  id_use_rs   in   1              instruction reads rs
//  id_use_rt   in   1              instruction reads rt
//  id_wr_en    in   1              instruction writes id_wr_reg
//  id_wr_reg   in   REG_BITS       destination reg
//  id_is_load  in   1              destination written from memory
//  flush       in   1              branch/jump taken; squash young work
//  hold        in   1              freeze whole pipeline (memory wait)
//  stall       out  1              freeze PC and IF/ID; bubble into EX
//  fwd_rs      out  FWD_W          rs source: 0 = regfile, k+1 = stage entry k will occupy next cycle
//  fwd_rt      out  FWD_W          same for rt; FWD_W = $clog2(DEPTH+1)
//  inflight    out  FWD_W          count of valid entries
// BEHAVIOUR
//  State: entry[k] = {v, dst, ld}, k = 0..DEPTH-1. Reset clears all v.
//  After reset: stall=0, fwd_rs=fwd_rt=0, inflight=0.
//  Match (operand r, entry k):
//    - entry[k].v && entry[k].dst==r && r!=0 && operand used && id_valid.
//    - Youngest match (lowest k) wins; older matches are ignored.
//  Ready: k+1 >= (ld ? LOAD_AVAIL : ALU_AVAIL).
//  stall = !hold && !flush && any winning match not ready. Combinational.
//  fwd_x = k+1 of the winning match; 0 if no match or reg 0.
//    - Combinational; valid only when stall=0.
//  Update priority (per edge): rst > hold > flush > stall > normal.
//    - hold: all entries keep their value; stall output forced 0.
//      A flush during hold is ignored; the requester keeps flush high until hold drops.
//    - flush: shift entries up by one; the ID instruction is not issued.
//      Entries 0..FLUSH_DEPTH-1 after the shift have v cleared.
//    - stall: shift entries up; entry[0] <= bubble (v=0).
//    - normal: shift entries up; entry[0] <= {id_valid&&id_wr_en&&id_wr_reg!=0, id_wr_reg, id_is_load}.
//  The shift drops entry[DEPTH-1]; its write has committed to the regfile, so it never matches.
//  A WB-stage write and an ID read of the same reg in one cycle are forwarded from entry DEPTH-1 (no regfile bypass assumed).
//  inflight = popcount(v), registered, updated with the entries.
//  Cleanup: with no new issue, all entries drain in DEPTH normal/stall cycles.
//  Reset mid-operation clears all entries on the next edge; no partial state survives.
// TESTING (DEPTH=3, ALU_AVAIL=1, LOAD_AVAIL=2)
//  1. Issue add r3; next cycle ID reads rs=r3 -> stall=0, fwd_rs=1; one cycle later fwd_rs=2.
//  2. Issue lw r5; next cycle ID uses rt=r5 -> stall=1 for one cycle, then stall=0, fwd_rt=2.
//  3. add r4 issued, then add r4 again; ID reads r4 -> fwd=1 (youngest), not 2.
//  4. lw r7; in the next cycle flush=1 with an ID reader of r7 present:
//     - entry[0] is cleared, stall=0.
//     - entry for r7 now at k=1; a reader of r7 on the following edge gets fwd=2.
//  5. hold=1 for 3 cycles with entries {r2,r6}: entries and inflight=2 are unchanged, stall=0.
//     After hold drops, the pipeline resumes the same match.
//  6. Writes to r0, rst mid-stream, and 4 idle cycles: r0 never stalls/forwards; reset gives inflight=0; idle drain gives inflight=0.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// In-flight write scoreboard beside ID: stall on unready producers
// and pick the youngest forwarding source for each operand.
module pipe_scoreboard #(
    parameter int REG_BITS    = 5,
    parameter int DEPTH       = 3,
    parameter int ALU_AVAIL   = 1,
    parameter int LOAD_AVAIL  = 2,
    parameter int FLUSH_DEPTH = 1,
    localparam int FWD_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_wr_en,
    input  logic [REG_BITS-1:0] id_wr_reg,
    input  logic                id_is_load,
    input  logic                flush,
    input  logic                hold,
    output logic                stall,
    output logic [FWD_W-1:0]    fwd_rs,
    output logic [FWD_W-1:0]    fwd_rt,
    output logic [FWD_W-1:0]    inflight
);

    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] dst;
        logic                ld;
    } entry_t;

    entry_t              ent_q [DEPTH];
    entry_t              ent_d [DEPTH];
    logic [FWD_W-1:0]    cnt_q;
    logic [FWD_W-1:0]    cnt_d;

    logic [REG_BITS-1:0] src [2];
    logic [1:0]          use_src;
    logic [1:0]          hit;
    logic [1:0]          rdy;
    logic [FWD_W-1:0]    idx [2];

    assign src[0]  = id_rs;
    assign src[1]  = id_rt;
    assign use_src = {id_use_rt, id_use_rs};

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        hit = '0;
        rdy = '1;
        for (int op = 0; op < 2; op++) begin
            idx[op] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_valid && use_src[op] && (src[op] != '0) &&
                    ent_q[k].v && (ent_q[k].dst == src[op])) begin
                    hit[op] = 1'b1;
                    idx[op] = FWD_W'(k + 1);
                    rdy[op] = (k + 1) >=
                        (ent_q[k].ld ? LOAD_AVAIL : ALU_AVAIL);
                end
            end
        end
    end

    assign stall = !hold && !flush &&
                   ((hit[0] && !rdy[0]) || (hit[1] && !rdy[1]));

    assign fwd_rs   = idx[0];
    assign fwd_rt   = idx[1];
    assign inflight = cnt_q;

    always_comb begin
        ent_d = ent_q;
        cnt_d = '0;
        if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_d[k] = ent_q[k - 1];
            end
            ent_d[0] = '0;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k < FLUSH_DEPTH) begin
                        ent_d[k].v = 1'b0;
                    end
                end
            end else if (!stall) begin
                ent_d[0].v   = id_valid && id_wr_en &&
                               (id_wr_reg != '0);
                ent_d[0].dst = id_wr_reg;
                ent_d[0].ld  = id_is_load;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            cnt_d = cnt_d + FWD_W'(ent_d[k].v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed vector table followed by
// random traffic checked against a queue-based pipeline model.
module tb_pipe_scoreboard;

    localparam int REG_BITS    = 5;
    localparam int DEPTH       = 3;
    localparam int ALU_AVAIL   = 1;
    localparam int LOAD_AVAIL  = 2;
    localparam int FLUSH_DEPTH = 1;
    localparam int FWD_W       = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_use_rs;
    logic                id_use_rt;
    logic                id_wr_en;
    logic [REG_BITS-1:0] id_wr_reg;
    logic                id_is_load;
    logic                flush;
    logic                hold;
    logic                stall;
    logic [FWD_W-1:0]    fwd_rs;
    logic [FWD_W-1:0]    fwd_rt;
    logic [FWD_W-1:0]    inflight;

    pipe_scoreboard #(
        .REG_BITS(REG_BITS), .DEPTH(DEPTH),
        .ALU_AVAIL(ALU_AVAIL), .LOAD_AVAIL(LOAD_AVAIL),
        .FLUSH_DEPTH(FLUSH_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .flush(flush), .hold(hold),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, v, rs, rt, urs, urt, we, wr, ld, fl, hd;
        int es, efs, eft, ei;
    } vec_t;

    typedef struct {
        bit v;
        int dst;
        bit ld;
    } slot_t;

    // mq[i] is the write that is i+1 stages past ID
    slot_t mq[$];
    vec_t  tab[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic vec_t mk(
        int rst, int v, int rs, int rt, int urs, int urt,
        int we, int wr, int ld, int fl, int hd,
        int es, int efs, int eft, int ei);
        vec_t t;
        t.rst = rst; t.v = v; t.rs = rs; t.rt = rt;
        t.urs = urs; t.urt = urt; t.we = we; t.wr = wr;
        t.ld = ld; t.fl = fl; t.hd = hd;
        t.es = es; t.efs = efs; t.eft = eft; t.ei = ei;
        return t;
    endfunction

    function automatic vec_t idle(int ei);
        return mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,ei);
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void lookup(vec_t t, int r, int u,
                                   output int f, output bit blk);
        f   = 0;
        blk = 1'b0;
        if (t.v == 0 || u == 0 || r == 0) return;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].v && mq[i].dst == r) begin
                f   = i + 1;
                blk = (i + 1) < (mq[i].ld ? LOAD_AVAIL : ALU_AVAIL);
                return;
            end
        end
    endfunction

    function automatic void model_eval(vec_t t, output int es,
        output int efs, output int eft, output int ei);
        bit b0, b1;
        lookup(t, t.rs, t.urs, efs, b0);
        lookup(t, t.rt, t.urt, eft, b1);
        es = (t.hd == 0 && t.fl == 0 && (b0 || b1)) ? 1 : 0;
        ei = 0;
        foreach (mq[i]) if (mq[i].v) ei++;
    endfunction

    function automatic void model_update(vec_t t, int es);
        slot_t s;
        if (t.rst != 0) begin
            mq.delete();
            return;
        end
        if (t.hd != 0) return;
        s = '{v: 1'b0, dst: 0, ld: 1'b0};
        if (t.fl == 0 && es == 0) begin
            s.v   = (t.v != 0 && t.we != 0 && t.wr != 0);
            s.dst = t.wr;
            s.ld  = (t.ld != 0);
        end
        mq.push_front(s);
        if (t.fl != 0) begin
            for (int i = 0; i < FLUSH_DEPTH && i < mq.size(); i++)
                mq[i].v = 1'b0;
        end
        while (mq.size() > DEPTH) void'(mq.pop_back());
    endfunction

    task automatic drive(vec_t t);
        rst        = (t.rst != 0);
        id_valid   = (t.v != 0);
        id_rs      = REG_BITS'(t.rs);
        id_rt      = REG_BITS'(t.rt);
        id_use_rs  = (t.urs != 0);
        id_use_rt  = (t.urt != 0);
        id_wr_en   = (t.we != 0);
        id_wr_reg  = REG_BITS'(t.wr);
        id_is_load = (t.ld != 0);
        flush      = (t.fl != 0);
        hold       = (t.hd != 0);
    endtask

    // Starts just after a rising edge; ends just after the next one.
    task automatic step(vec_t t, bit use_tab, string tag);
        int es, efs, eft, ei;
        drive(t);
        @(negedge clk);
        model_eval(t, es, efs, eft, ei);
        if (use_tab) begin
            check({tag, " stall"},    int'(stall),    t.es);
            check({tag, " fwd_rs"},   int'(fwd_rs),   t.efs);
            check({tag, " fwd_rt"},   int'(fwd_rt),   t.eft);
            check({tag, " inflight"}, int'(inflight), t.ei);
        end else begin
            check({tag, " stall"},    int'(stall),    es);
            check({tag, " fwd_rs"},   int'(fwd_rs),   efs);
            check({tag, " fwd_rt"},   int'(fwd_rt),   eft);
            check({tag, " inflight"}, int'(inflight), ei);
        end
        @(posedge clk);
        model_update(t, es);
        #1;
    endtask

    initial begin
        vec_t r;
        // rst v rs rt urs urt we wr ld fl hd | stall frs frt infl
        // add r3, read it at EX, MEM, WB, then gone
        tab.push_back(mk(0,1,0,0,0,0,1,3,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,3,0,1,0,0,0,0,0,0, 0,1,0,1));
        tab.push_back(mk(0,1,3,0,1,0,0,0,0,0,0, 0,2,0,1));
        tab.push_back(mk(0,1,3,0,1,0,0,0,0,0,0, 0,3,0,1));
        tab.push_back(mk(0,1,3,0,1,0,0,0,0,0,0, 0,0,0,0));
        // lw r5 then load-use on rt
        tab.push_back(mk(0,1,0,0,0,0,1,5,1,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,5,0,1,0,0,0,0,0, 1,0,1,1));
        tab.push_back(mk(0,1,0,5,0,1,0,0,0,0,0, 0,0,2,1));
        tab.push_back(idle(1));
        tab.push_back(idle(0));
        // two writers of r4: youngest wins
        tab.push_back(mk(0,1,0,0,0,0,1,4,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,4,0,1,0,1,4,0,0,0, 0,1,0,1));
        tab.push_back(mk(0,1,4,4,1,1,0,0,0,0,0, 0,1,1,2));
        tab.push_back(idle(2));
        tab.push_back(idle(1));
        tab.push_back(idle(0));
        // lw r7 then flush with a reader present
        tab.push_back(mk(0,1,0,0,0,0,1,7,1,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,7,0,1,0,0,0,1,0, 0,0,1,1));
        tab.push_back(mk(0,1,0,7,0,1,0,0,0,0,0, 0,0,2,1));
        tab.push_back(idle(1));
        tab.push_back(idle(0));
        // entries {r2, lw r6}, hold 3 cycles (flush ignored)
        tab.push_back(mk(0,1,0,0,0,0,1,2,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,0,0,0,1,6,1,0,0, 0,0,0,1));
        tab.push_back(mk(0,1,2,6,1,1,0,0,0,0,1, 0,2,1,2));
        tab.push_back(mk(0,1,2,6,1,1,0,0,0,0,1, 0,2,1,2));
        tab.push_back(mk(0,1,2,6,1,1,0,0,0,1,1, 0,2,1,2));
        tab.push_back(mk(0,1,2,6,1,1,0,0,0,0,0, 1,2,1,2));
        tab.push_back(mk(0,1,2,6,1,1,0,0,0,0,0, 0,3,2,2));
        tab.push_back(idle(1));
        tab.push_back(idle(0));
        // r0 writes never tracked; reset mid-stream
        tab.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,0,1,0,1,0,1,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,0,0,0,1,9,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,0,0,0,1,10,1,0,0, 0,0,0,1));
        tab.push_back(mk(1,1,9,10,1,1,0,0,0,0,0, 1,2,1,2));
        tab.push_back(mk(0,1,9,10,1,1,0,0,0,0,0, 0,0,0,0));
        // fill three entries then drain idle
        tab.push_back(mk(0,1,0,0,0,0,1,11,0,0,0, 0,0,0,0));
        tab.push_back(mk(0,1,0,0,0,0,1,12,0,0,0, 0,0,0,1));
        tab.push_back(mk(0,1,0,0,0,0,1,13,1,0,0, 0,0,0,2));
        tab.push_back(idle(3));
        tab.push_back(idle(2));
        tab.push_back(idle(1));
        tab.push_back(idle(0));

        drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        step(idle(0), 1'b1, "reset");

        foreach (tab[i]) step(tab[i], 1'b1, $sformatf("vec%0d", i));

        for (int c = 0; c < 600; c++) begin
            r.rst = ($urandom_range(0, 63) == 0) ? 1 : 0;
            r.v   = ($urandom_range(0, 7) != 0) ? 1 : 0;
            r.rs  = $urandom_range(0, 7);
            r.rt  = $urandom_range(0, 7);
            r.urs = $urandom_range(0, 1);
            r.urt = $urandom_range(0, 1);
            r.we  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r.wr  = $urandom_range(0, 7);
            r.ld  = $urandom_range(0, 1);
            r.fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            r.hd  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            r.es = 0; r.efs = 0; r.eft = 0; r.ei = 0;
            step(r, 1'b0, $sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
